// File: rtl/fifo_push_arbiter_pkg.sv
// Shared types and helpers for the FIFO push arbiter and other round-robin arbiters.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Largest requester count the generic pick function supports.
    localparam int MAX_REQ  = 16;
    localparam int MAX_ID_W = 4;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } pick_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  valid,
                                      input logic [MAX_ID_W-1:0] ptr,
                                      input int                  n);
        pick_t               r;
        int                  c;
        logic [MAX_ID_W-1:0] cidx;
        r = '0;
        // Walk offsets from farthest to nearest so the nearest valid one wins.
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                c    = (int'(ptr) + k) % n;
                cidx = MAX_ID_W'(c);
                if (valid[cidx]) begin
                    r.found = 1'b1;
                    r.idx   = cidx;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// Requester-side handshakes and FIFO push side bundled for the push arbiter.
interface fifo_push_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int ID_W = fifo_arb_pkg::id_w(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   fifo_push;
    logic [WIDTH-1:0]       fifo_push_data;
    logic                   fifo_full;
    logic                   grant_valid;
    logic [ID_W-1:0]        grant_id;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_push, fifo_push_data, grant_valid, grant_id
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_push, fifo_push_data, grant_valid, grant_id
    );

endinterface

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational round-robin pick: first valid requester at or after ptr_i, circularly.
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic             found_o,
    output logic [ID_W-1:0]  idx_o
);

    logic [MAX_REQ-1:0]  valid_ext;
    logic [MAX_ID_W-1:0] ptr_ext;
    pick_t               pick;

    assign valid_ext = MAX_REQ'(valid_i);
    assign ptr_ext   = MAX_ID_W'(ptr_i);

    always_comb begin
        pick = rr_pick(valid_ext, ptr_ext, N_REQ);
    end

    assign found_o = pick.found;
    assign idx_o   = ID_W'(pick.idx);

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO push port between N_REQ producers.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    fifo_push_arbiter_if.master bus
);

    localparam int ID_W = id_w(N_REQ);
    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(MAX_BURST - 1);

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  cur_id_q, cur_id_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]  burst_cnt_q, burst_cnt_d;

    logic [WIDTH-1:0] data_arr [N_REQ];
    logic [ID_W-1:0]  next_ptr;
    logic [ID_W-1:0]  pick_ptr;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_found;
    logic             busy;
    logic             cur_valid;
    logic             xfer;
    logic             release_grant;

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign data_arr[g] = bus.req_data[g*WIDTH +: WIDTH];
    end

    assign busy      = (state_q == BUSY);
    assign cur_valid = bus.req_valid[cur_id_q];
    assign xfer      = busy && cur_valid && !bus.fifo_full;
    assign next_ptr  = (cur_id_q == ID_W'(N_REQ - 1)) ? '0 : cur_id_q + ID_W'(1);

    // In BUSY the picker only matters on release, when rr_ptr moves past cur_id.
    assign pick_ptr  = busy ? next_ptr : rr_ptr_q;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .valid_i (bus.req_valid),
        .ptr_i   (pick_ptr),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign release_grant = busy && ((xfer && (burst_cnt_q == LAST_BEAT)) || !cur_valid);

    always_comb begin
        bus.req_ready = '0;
        if (busy && !rst && !bus.fifo_full) begin
            bus.req_ready[cur_id_q] = 1'b1;
        end
    end

    assign bus.fifo_push      = xfer && !rst;
    assign bus.fifo_push_data = data_arr[cur_id_q];
    assign bus.grant_valid    = busy && !rst;
    assign bus.grant_id       = (busy && !rst) ? cur_id_q : '0;

    always_comb begin
        state_d     = state_q;
        cur_id_d    = cur_id_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = BUSY;
                    cur_id_d    = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            BUSY: begin
                if (xfer) begin
                    burst_cnt_d = burst_cnt_q + BC_W'(1);
                end
                if (release_grant) begin
                    rr_ptr_d    = next_ptr;
                    burst_cnt_d = '0;
                    if (pick_found) begin
                        cur_id_d = pick_idx;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_id_q    <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_id_q    <= cur_id_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter: vector table, directed corner cases, random run vs model.
module tb_fifo_push_arbiter;
    import fifo_arb_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_push_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    fifo_push_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: who owns the port, where the rotation starts, beats granted so far.
    bit m_busy;
    int m_owner, m_ptr, m_beats;

    logic       s_gv, s_push;
    logic [1:0] s_gid;
    logic [3:0] s_ready;
    logic [7:0] s_data;

    bit         prod_mode;
    int         remain [N];
    logic [7:0] nextd  [N];
    logic [7:0] pushed [$];

    typedef struct {
        bit         rst;
        logic [3:0] valid;
        bit         full;
        logic       gv;
        logic [1:0] gid;
        logic       push;
        logic [3:0] ready;
    } vec_t;
    vec_t tbl [$];

    function automatic int first_from(input int ptr, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive_prod();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]           = (remain[i] > 0);
            bus.req_data[i*W +: W]     = nextd[i];
        end
    endtask

    task automatic cycle();
        logic [N-1:0] v;
        logic         full;
        logic         e_gv, e_push;
        logic [1:0]   e_gid;
        logic [3:0]   e_ready;
        logic [7:0]   e_data;
        int           nb;
        @(negedge clk);
        cyc++;
        v       = bus.req_valid;
        full    = bus.fifo_full;
        s_gv    = bus.grant_valid;
        s_gid   = bus.grant_id;
        s_ready = bus.req_ready;
        s_push  = bus.fifo_push;
        s_data  = bus.fifo_push_data;
        e_gv = 1'b0; e_gid = '0; e_ready = '0; e_push = 1'b0; e_data = '0;
        if (!rst && m_busy) begin
            e_gv    = 1'b1;
            e_gid   = 2'(m_owner);
            e_ready = full ? 4'b0 : 4'(1 << m_owner);
            e_push  = v[m_owner] && !full;
            e_data  = bus.req_data[m_owner*W +: W];
        end
        chk("model_outputs", {s_gv, s_gid, s_ready, s_push}, {e_gv, e_gid, e_ready, e_push});
        if (e_push) chk("model_push_data", s_data, e_data);
        if (s_push) pushed.push_back(s_data);
        if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
        end else if (!m_busy) begin
            if (v != '0) begin
                m_busy  = 1;
                m_owner = first_from(m_ptr, v);
                m_beats = 0;
            end
        end else begin
            if (e_push) m_beats++;
            if (!v[m_owner] || m_beats == MB) begin
                m_ptr = (m_owner + 1) % N;
                nb    = first_from(m_ptr, v);
                m_beats = 0;
                if (nb >= 0) m_owner = nb;
                else         m_busy  = 0;
            end
        end
        if (prod_mode) begin
            for (int i = 0; i < N; i++) begin
                if (v[i] && s_ready[i]) begin
                    remain[i]--;
                    nextd[i]++;
                end
            end
        end
        @(posedge clk);
        #1;
        if (prod_mode) drive_prod();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int first_push, last_push;
        vec_t t;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        bus.fifo_full = 1'b0;
        prod_mode = 0;
        m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;

        // Reset with all valid, then full contention rotating 0,1,2,3,0 in 4-beat bursts.
        tbl.push_back('{1, 4'hF, 0, 0, 2'd0, 0, 4'h0});
        tbl.push_back('{1, 4'hF, 0, 0, 2'd0, 0, 4'h0});
        tbl.push_back('{0, 4'hF, 0, 0, 2'd0, 0, 4'h0});
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < MB; k++) begin
                tbl.push_back('{0, 4'hF, 0, 1, 2'(b % N), 1, 4'(1 << (b % N))});
            end
        end
        foreach (tbl[i]) begin
            t = tbl[i];
            rst = t.rst;
            bus.req_valid = t.valid;
            bus.fifo_full = t.full;
            cycle();
            chk($sformatf("vec%0d", i), {s_gv, s_gid, s_push, s_ready}, {t.gv, t.gid, t.push, t.ready});
        end

        // Single stream from requester 2: six beats, regranted without a bubble.
        bus.req_valid = '0;
        do_reset();
        for (int i = 0; i < N; i++) begin remain[i] = 0; nextd[i] = 8'h00; end
        remain[2] = 6;
        nextd[2]  = 8'h10;
        prod_mode = 1;
        drive_prod();
        pushed.delete();
        first_push = -1; last_push = -1;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (s_push) begin
                if (first_push < 0) first_push = cyc;
                last_push = cyc;
                chk("t2_gid", s_gid, 2);
            end
        end
        prod_mode = 0;
        chk("t2_push_count", pushed.size(), 6);
        chk("t2_no_bubble", last_push - first_push + 1, 6);
        for (int k = 0; k < 6; k++) begin
            if (k < pushed.size()) chk($sformatf("t2_data%0d", k), pushed[k], 8'h10 + k);
        end

        // Backpressure during requester 0's burst.
        bus.req_valid = '0;
        bus.req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        do_reset();
        bus.req_valid = 4'b0011;
        cycle();
        cycle(); chk("t4_beat1", {s_gid, s_push}, {2'd0, 1'b1});
        cycle(); chk("t4_beat2", {s_gid, s_push}, {2'd0, 1'b1});
        bus.fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t4_stall", {s_gv, s_gid, s_push, s_ready}, {1'b1, 2'd0, 1'b0, 4'b0});
        end
        bus.fifo_full = 1'b0;
        cycle(); chk("t4_beat3", {s_gid, s_push}, {2'd0, 1'b1});
        cycle(); chk("t4_beat4", {s_gid, s_push}, {2'd0, 1'b1});
        cycle(); chk("t4_next", {s_gid, s_push, s_data}, {2'd1, 1'b1, 8'hB1});

        // Requester 1 drops valid after two beats while 2 and 3 wait.
        bus.req_valid = '0;
        do_reset();
        for (int i = 0; i < N; i++) begin remain[i] = 100; nextd[i] = 8'(8'h40 * i); end
        remain[0] = 0;
        remain[1] = 2;
        prod_mode = 1;
        drive_prod();
        cycle();
        cycle(); chk("t5_beat1", {s_gid, s_push}, {2'd1, 1'b1});
        cycle(); chk("t5_beat2", {s_gid, s_push}, {2'd1, 1'b1});
        cycle(); chk("t5_drop", {s_gv, s_gid, s_push}, {1'b1, 2'd1, 1'b0});
        cycle(); chk("t5_next", {s_gid, s_push}, {2'd2, 1'b1});
        prod_mode = 0;

        // Reset during beat 2 of requester 3; pointer returns to 0.
        bus.req_valid = '0;
        bus.req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        do_reset();
        bus.req_valid = 4'b1000;
        cycle();
        cycle(); chk("t6_beat1", {s_gid, s_push}, {2'd3, 1'b1});
        rst = 1'b1;
        bus.req_valid = 4'b1001;
        cycle(); chk("t6_in_reset", {s_gv, s_gid, s_push, s_ready}, 8'h0);
        rst = 1'b0;
        cycle(); chk("t6_idle", {s_gv, s_push}, 2'b00);
        cycle(); chk("t6_regrant", {s_gv, s_gid, s_push}, {1'b1, 2'd0, 1'b1});

        // Random traffic with random backpressure and rare resets.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            bus.req_valid = 4'($urandom_range(0, 15));
            bus.req_data  = 32'($urandom);
            bus.fifo_full = ($urandom_range(0, 3) == 0);
            rst           = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
